fp_add_arbiter: RTL and testbench

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

---
 rtl/fp_add_arbiter.sv | 88 ++++++++
 tb/tb_fp_add_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
`default_nettype none
// fp_add_arbiter: round-robin front end sharing one combinational FP adder between two requesters.
// Rev 1.0 -- initial release.
module fp_add_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  input  logic [W-1:0] add_sum,
  input  logic         add_overflow,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   pend_id;
  logic   grant;
  logic   accept;

  always_comb begin
    state_nxt = state;
    // On a tie the port that was not granted last wins.
    grant     = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    accept    = (state == IDLE) & (req0_valid | req1_valid);
    // Ready is masked by reset so nothing looks accepted while the block is held.
    req0_ready = accept & ~grant & rst_n;
    req1_ready = accept &  grant & rst_n;
    case (state)
      IDLE:    if (accept)    state_nxt = ISSUE;
      ISSUE:                  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      pend_id      <= 1'b0;
      add_a        <= '0;
      add_b        <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_sum      <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        add_a      <= grant ? req1_a : req0_a;
        add_b      <= grant ? req1_b : req0_b;
        pend_id    <= grant;
        last_grant <= grant;
      end
      if (state == ISSUE) begin
        rsp_sum      <= add_sum;
        rsp_overflow <= add_overflow;
        rsp_id       <= pend_id;
        rsp_valid    <= 1'b1;
      end
      if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`default_nettype none
// tb_fp_add_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Rev 1.0 -- initial release.
module tb_fp_add_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_overflow;
  logic         rsp_valid, rsp_ready, rsp_id, rsp_overflow;
  logic [W-1:0] rsp_sum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Stand-in for the external adder: known IEEE vectors, otherwise a scrambled tag.
  function automatic logic [W:0] adder_model(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) return {1'b0, 32'h40400000};
    if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF) return {1'b1, 32'h7F800000};
    return {a[3] ^ b[5], a ^ {b[15:0], b[31:16]}};
  endfunction

  function automatic logic [W-1:0] rand_op();
    return ($urandom_range(7, 0) == 0) ? 32'h7F7FFFFF : $urandom();
  endfunction

  assign {add_overflow, add_sum} = adder_model(add_a, add_b);

  fp_add_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_overflow(add_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_overflow(rsp_overflow)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    settle();
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_sum !== '0 || rsp_overflow !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: got v=%b id=%b sum=%h ov=%b expected all 0",
                         rsp_valid, rsp_id, rsp_sum, rsp_overflow);
    end
    checks++;
    if (add_a !== '0 || add_b !== '0) begin
      errors++; $display("FAIL reset_add: got a=%h b=%h expected 0", add_a, add_b);
    end
    clear_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    req0_valid = 1'b1; req0_a = 32'h3F800000; req0_b = 32'h40000000; rsp_ready = 1'b1;
    settle();
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL single_grant: got %b%b expected 10", req0_ready, req1_ready);
    end
    next_cycle();
    req0_valid = 1'b0;
    settle();
    checks++;
    if (rsp_valid !== 1'b0 || add_a !== 32'h3F800000 || add_b !== 32'h40000000) begin
      errors++; $display("FAIL single_issue: got v=%b a=%h b=%h expected 0 3f800000 40000000",
                         rsp_valid, add_a, add_b);
    end
    next_cycle();
    settle();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_sum !== 32'h40400000 || rsp_overflow !== 1'b0) begin
      errors++; $display("FAIL single_rsp: got v=%b id=%b sum=%h ov=%b expected 1 0 40400000 0",
                         rsp_valid, rsp_id, rsp_sum, rsp_overflow);
    end
    next_cycle();
    settle();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: got v=%b expected 0", rsp_valid);
    end
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] a0, b0, a1, b1;
    logic [W:0]   exp;
    int           eid;
    a0 = rand_op(); b0 = rand_op(); a1 = rand_op(); b1 = rand_op();
    apply_reset();
    req0_valid = 1'b1; req0_a = a0; req0_b = b0;
    req1_valid = 1'b1; req1_a = a1; req1_b = b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) next_cycle();
      settle();
      checks++;
      if (req0_ready !== (k % 6 == 0) || req1_ready !== (k % 6 == 3)) begin
        errors++; $display("FAIL simul_grant cycle %0d: got %b%b expected %b%b", k,
                           req0_ready, req1_ready, (k % 6 == 0), (k % 6 == 3));
      end
      if (k % 3 == 2) begin
        eid = (k / 3) % 2;
        exp = (eid == 1) ? adder_model(a1, b1) : adder_model(a0, b0);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== eid[0] || {rsp_overflow, rsp_sum} !== exp) begin
          errors++; $display("FAIL simul_rsp cycle %0d: got v=%b id=%b res=%h expected 1 %0d %h",
                             k, rsp_valid, rsp_id, {rsp_overflow, rsp_sum}, eid, exp);
        end
      end else begin
        checks++;
        if (rsp_valid !== 1'b0) begin
          errors++; $display("FAIL simul_idle cycle %0d: got v=%b expected 0", k, rsp_valid);
        end
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [W:0] exp;
    apply_reset();
    req0_valid = 1'b1; req0_a = rand_op(); req0_b = rand_op(); rsp_ready = 1'b0;
    exp = adder_model(req0_a, req0_b);
    settle();
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL bp_grant: got %b expected 1", req0_ready);
    end
    next_cycle();
    req0_valid = 1'b0; req1_valid = 1'b1; req1_a = rand_op(); req1_b = rand_op();
    settle();
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      rsp_ready = (k == 5);
      settle();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || {rsp_overflow, rsp_sum} !== exp ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cycle %0d: got v=%b id=%b res=%h rdy=%b%b expected 1 0 %h 00",
                           k, rsp_valid, rsp_id, {rsp_overflow, rsp_sum}, req0_ready, req1_ready, exp);
      end
    end
    next_cycle();
    settle();
    checks++;
    if (rsp_valid !== 1'b0 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL bp_resume: got v=%b rdy=%b%b expected 0 01", rsp_valid, req0_ready, req1_ready);
    end
    exp = adder_model(req1_a, req1_b);
    next_cycle();
    req1_valid = 1'b0;
    next_cycle();
    settle();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || {rsp_overflow, rsp_sum} !== exp) begin
      errors++; $display("FAIL bp_pending: got v=%b id=%b res=%h expected 1 1 %h",
                         rsp_valid, rsp_id, {rsp_overflow, rsp_sum}, exp);
    end
    next_cycle();
  endtask

  task automatic test_overflow();
    apply_reset();
    req1_valid = 1'b1; req1_a = 32'h7F7FFFFF; req1_b = 32'h7F7FFFFF; rsp_ready = 1'b1;
    settle();
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL ovf_grant: got %b%b expected 01", req0_ready, req1_ready);
    end
    next_cycle();
    req1_valid = 1'b0;
    next_cycle();
    settle();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_overflow !== 1'b1 || rsp_id !== 1'b1 || rsp_sum !== 32'h7F800000) begin
      errors++; $display("FAIL ovf_rsp: got v=%b ov=%b id=%b sum=%h expected 1 1 1 7f800000",
                         rsp_valid, rsp_overflow, rsp_id, rsp_sum);
    end
    next_cycle();
  endtask

  task automatic test_reset_midop();
    logic [W:0] exp;
    apply_reset();
    req0_valid = 1'b1; req0_a = rand_op(); req0_b = rand_op(); rsp_ready = 1'b1;
    settle();
    next_cycle();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = rand_op(); req1_b = rand_op();
    exp = adder_model(req1_a, req1_b);
    rst_n = 1'b0;
    settle();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_sum !== '0 || rsp_overflow !== 1'b0 ||
        add_a !== '0 || add_b !== '0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL midop_reset: got v=%b id=%b sum=%h ov=%b a=%h b=%h rdy=%b%b expected all 0",
                         rsp_valid, rsp_id, rsp_sum, rsp_overflow, add_a, add_b, req0_ready, req1_ready);
    end
    next_cycle();
    settle();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL midop_dropped: got v=%b expected 0", rsp_valid);
    end
    next_cycle();
    rst_n = 1'b1;
    settle();
    checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL midop_regrant: got %b%b expected 01", req0_ready, req1_ready);
    end
    next_cycle();
    req1_valid = 1'b0;
    next_cycle();
    settle();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || {rsp_overflow, rsp_sum} !== exp) begin
      errors++; $display("FAIL midop_rsp: got v=%b id=%b res=%h expected 1 1 %h",
                         rsp_valid, rsp_id, {rsp_overflow, rsp_sum}, exp);
    end
    next_cycle();
  endtask

  task automatic test_single_repeat();
    logic [W:0] exp;
    logic       reload;
    apply_reset();
    req1_valid = 1'b1; req1_a = rand_op(); req1_b = rand_op(); rsp_ready = 1'b1;
    exp = '0; reload = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (k > 0) next_cycle();
      if (reload) begin
        req1_a = rand_op(); req1_b = rand_op(); reload = 1'b0;
      end
      settle();
      checks++;
      if (req1_ready !== (k % 3 == 0) || req0_ready !== 1'b0) begin
        errors++; $display("FAIL repeat_grant cycle %0d: got %b%b expected 0%b", k,
                           req0_ready, req1_ready, (k % 3 == 0));
      end
      if (k % 3 == 0) begin
        exp = adder_model(req1_a, req1_b);
        reload = 1'b1;
      end
      if (k % 3 == 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || {rsp_overflow, rsp_sum} !== exp) begin
          errors++; $display("FAIL repeat_rsp cycle %0d: got v=%b id=%b res=%h expected 1 1 %h",
                             k, rsp_valid, rsp_id, {rsp_overflow, rsp_sum}, exp);
        end
      end
    end
    req1_valid = 1'b0;
  endtask

  // Transaction-level model: one operation in flight, response two cycles after acceptance,
  // round-robin choice between pending requesters.
  task automatic test_random();
    logic [W-1:0] qa [2];
    logic [W-1:0] qb [2];
    logic         v [2];
    logic         busy, last, exp_id, g, gv, erv;
    logic [W-1:0] exp_a, exp_b;
    logic [W:0]   exp_res;
    int           acc_k;
    busy = 1'b0; last = 1'b1; acc_k = 0; exp_id = 1'b0;
    exp_a = '0; exp_b = '0; exp_res = '0;
    for (int p = 0; p < 2; p++) begin
      qa[p] = '0; qb[p] = '0; v[p] = 1'b0;
    end
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      if (k > 0) next_cycle();
      for (int p = 0; p < 2; p++) begin
        if (!v[p] && $urandom_range(1, 0) == 1) begin
          v[p] = 1'b1; qa[p] = rand_op(); qb[p] = rand_op();
        end
      end
      req0_valid = v[0]; req0_a = qa[0]; req0_b = qb[0];
      req1_valid = v[1]; req1_a = qa[1]; req1_b = qb[1];
      rsp_ready  = ($urandom_range(2, 0) != 0);
      settle();
      gv  = !busy && (v[0] || v[1]);
      g   = (v[0] && v[1]) ? ~last : v[1];
      erv = busy && (k >= acc_k + 2);
      checks++;
      if (req0_ready !== (gv && !g) || req1_ready !== (gv && g)) begin
        errors++; $display("FAIL rand_grant cycle %0d: got %b%b expected %b%b", k,
                           req0_ready, req1_ready, gv && !g, gv && g);
      end
      checks++;
      if (rsp_valid !== erv) begin
        errors++; $display("FAIL rand_valid cycle %0d: got %b expected %b", k, rsp_valid, erv);
      end
      if (erv) begin
        checks++;
        if (rsp_id !== exp_id || {rsp_overflow, rsp_sum} !== exp_res) begin
          errors++; $display("FAIL rand_rsp cycle %0d: got id=%b res=%h expected %b %h", k,
                             rsp_id, {rsp_overflow, rsp_sum}, exp_id, exp_res);
        end
      end
      if (busy && k == acc_k + 1) begin
        checks++;
        if (add_a !== exp_a || add_b !== exp_b) begin
          errors++; $display("FAIL rand_operands cycle %0d: got %h %h expected %h %h", k,
                             add_a, add_b, exp_a, exp_b);
        end
      end
      if (erv && rsp_ready) busy = 1'b0;
      if (gv) begin
        busy = 1'b1; acc_k = k; last = g; exp_id = g;
        exp_a = qa[g]; exp_b = qb[g]; exp_res = adder_model(exp_a, exp_b);
        v[g] = 1'b0;
      end
    end
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_overflow();
    test_reset_midop();
    test_single_repeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
